mem_seq: RTL and testbench
==========================

MEM_SEQ -- requirements
Module: mem_seq

Interface
REQ-001 The block SHALL have one clock and an asynchronous, active-high reset. Ports are listed below; clock and reset come first.
REQ-002 clk  in  1  system clock; all state changes on its rising edge.
REQ-003 rst  in  1  asynchronous reset, active high.
REQ-004 if_req  in  1  instruction fetch request; held with if_addr stable until if_ack.
REQ-005 if_addr  in  16  fetch byte address; bit 0 ignored (treated as 0).
REQ-006 if_ack  out  1  one-cycle pulse: fetch complete, if_rdata valid.
REQ-007 if_rdata  out  16  fetched word.
REQ-008 d_req  in  1  data request; held with d_we, d_wb, d_addr and d_wdata stable until d_ack.
REQ-009 d_we  in  1  1 = write, 0 = read.
REQ-010 d_wb  in  1  1 = byte access, 0 = word access.
REQ-011 d_addr  in  16  data byte address.
REQ-012 d_wdata  in  16  write data; byte writes use [7:0].
REQ-013 d_ack  out  1  one-cycle pulse: data access complete, d_rdata valid for reads.
REQ-014 d_rdata  out  16  read data; byte reads are zero-extended into [7:0].
REQ-015 m_en  out  1  memory cycle strobe.
REQ-016 m_we  out  2  byte-lane write enables; [1] = lane [15:8] (even byte), [0] = lane [7:0] (odd byte).
REQ-017 m_addr  out  15  memory word address (byte address >> 1).
REQ-018 m_wdata  out  16  memory write data.
REQ-019 m_rdata  in  16  memory read data, valid in the cycle after a read strobe (m_en=1, m_we=00).

Function
REQ-020 Byte order SHALL be big-endian: the byte at an even address is lane [15:8]; a word at address A is {byte A, byte A+1}.
REQ-021 The FSM SHALL have states IDLE, CMD1, CMD2, RWAIT and ACK. Requests SHALL be sampled only in IDLE; the winning request's fields SHALL be latched on the accepting edge.
REQ-022 Arbitration SHALL be round-robin: when both requests are high in IDLE, the port not granted last SHALL win; a lone request SHALL always win.
REQ-023 Memory cycles: CMD1 SHALL drive m_en=1 and m_addr=A[15:1]. CMD2 SHALL drive m_en=1 and m_addr=(A+1)[15:1], with A+1 computed mod 2^16 so that 0xFFFF wraps to 0x0000. In all other states m_en=0, m_we=00 and m_addr=0.
REQ-024 Split rule: a data word access with A[0]=1 SHALL go CMD1 -> CMD2. All other accesses, including every fetch, SHALL use CMD1 only.
REQ-025 Transition table:
- Reads: last CMD -> RWAIT -> ACK.
- Writes: last CMD -> ACK.
- ACK -> IDLE, unconditionally.
REQ-026 Latency, counting C0 as the IDLE accept cycle:
- aligned read/fetch: ack in C3
- unaligned read: ack in C4
- aligned or byte write: ack in C2
- unaligned write: ack in C3
REQ-027 The read-data capture lane SHALL be:
- aligned word: [15:0] <- m_rdata
- byte read: [7:0] <- m_rdata[15:8] if A[0]=0, else m_rdata[7:0]
- unaligned word, first cycle (captured in CMD2): [15:8] <- m_rdata[7:0]
- unaligned word, second cycle (captured in RWAIT): [7:0] <- m_rdata[15:8]
REQ-028 Writes:
- byte write: m_wdata={d_wdata[7:0],d_wdata[7:0]}, m_we=10 if A[0]=0 else 01
- aligned word write: m_wdata=d_wdata, m_we=11
- unaligned word write, CMD1: m_we=01, m_wdata[7:0]=d_wdata[15:8]
- unaligned word write, CMD2: m_we=10, m_wdata[15:8]=d_wdata[7:0]
REQ-029 if_ack and d_ack SHALL be high only in ACK, only for the granted port. if_rdata and d_rdata SHALL hold their value until that port's next capture.
REQ-030 Requests are not sampled during ACK; a requester that keeps its request high after ack SHALL be re-arbitrated in the following IDLE cycle.

Reset
REQ-031 On rst: state=IDLE, last-grant=fetch (so data wins the first tie), and all outputs (acks, m_en, m_we, m_addr, m_wdata, rdata registers) SHALL be 0.
REQ-032 Reset asserted mid-access SHALL abandon the access with no ack and no further memory strobes.

Verification
REQ-033 Aligned data read, d_addr=0x0010, memory word 0x0008=0xABCD -> m_en in C1 with m_addr=0x0008, d_ack in C3, d_rdata=0xABCD.
REQ-034 Unaligned word read, d_addr=0x0011, words 0x0008=0x1122 and 0x0009=0x3344 -> two strobes (C1, C2), d_ack in C4, d_rdata=0x2233.
REQ-035 Unaligned word write, d_addr=0xFFFF, d_wdata=0xBEEF -> C1: m_addr=0x7FFF, m_we=01, lane [7:0]=0xBE; C2: m_addr=0x0000, m_we=10, lane [15:8]=0xEF; d_ack in C3.
REQ-036 Byte write then byte read, d_addr=0x0005, d_wdata=0x005A -> write uses m_we=01; the read returns d_rdata=0x005A.
REQ-037 if_req and d_req held high continuously from reset -> grants alternate D, I, D, I, with no ack overlap and no lost request.
REQ-038 rst pulsed during CMD2 of an unaligned read -> no d_ack, all outputs 0, and the next request completes normally.

Source files
------------

// File: rtl/mem_seq.sv
// -----------------------------------------------------------------------------
// mem_seq : arbitrating memory sequencer for an instruction-fetch port and a
// data port sharing one 16-bit wide, byte-lane-writable synchronous memory.
//
// Byte order is big-endian: the even byte of a word sits in lane [15:8].
// Unaligned data word accesses are split into two memory cycles (CMD1, CMD2).
// Fetches always use a single aligned cycle (if_addr[0] is ignored).
//
// Ports
//   clk       in   1  system clock, rising edge
//   rst       in   1  asynchronous reset, active high
//   if_req    in   1  fetch request, held until if_ack
//   if_addr   in  16  fetch byte address (bit 0 ignored)
//   if_ack    out  1  one-cycle pulse, if_rdata valid
//   if_rdata  out 16  fetched word (held until next fetch capture)
//   d_req     in   1  data request, held until d_ack
//   d_we      in   1  1 = write, 0 = read
//   d_wb      in   1  1 = byte access, 0 = word access
//   d_addr    in  16  data byte address
//   d_wdata   in  16  write data (byte writes use [7:0])
//   d_ack     out  1  one-cycle pulse, d_rdata valid for reads
//   d_rdata   out 16  read data (byte reads zero-extended into [7:0])
//   m_en      out  1  memory cycle strobe
//   m_we      out  2  lane write enables, [1] = lane [15:8], [0] = lane [7:0]
//   m_addr    out 15  memory word address
//   m_wdata   out 16  memory write data
//   m_rdata   in  16  memory read data, valid the cycle after a read strobe
// -----------------------------------------------------------------------------
module mem_seq (
  input  logic        clk,
  input  logic        rst,
  input  logic        if_req,
  input  logic [15:0] if_addr,
  output logic        if_ack,
  output logic [15:0] if_rdata,
  input  logic        d_req,
  input  logic        d_we,
  input  logic        d_wb,
  input  logic [15:0] d_addr,
  input  logic [15:0] d_wdata,
  output logic        d_ack,
  output logic [15:0] d_rdata,
  output logic        m_en,
  output logic [1:0]  m_we,
  output logic [14:0] m_addr,
  output logic [15:0] m_wdata,
  input  logic [15:0] m_rdata
);

  typedef enum logic [2:0] {
    IDLE  = 3'd0,
    CMD1  = 3'd1,
    CMD2  = 3'd2,
    RWAIT = 3'd3,
    ACK   = 3'd4
  } state_t;

  state_t      state_q, state_d;
  logic        last_d_q, last_d_d;    // 1 = data port was granted last
  logic        gnt_d_q, gnt_d_d;      // 1 = current access belongs to data port
  logic        we_q, we_d;
  logic        wb_q, wb_d;
  logic [15:0] addr_q, addr_d;
  logic [15:0] wdata_q, wdata_d;
  logic [15:0] if_rdata_q, if_rdata_d;
  logic [15:0] d_rdata_q, d_rdata_d;

  logic pick_d;      // arbitration result in IDLE
  logic is_read;     // latched access is a read (fetches are always reads)
  logic unaligned;   // latched access is a split data word access

  // Data wins when alone, or on a tie when fetch was granted last.
  assign pick_d    = d_req && (!if_req || !last_d_q);
  assign is_read   = !gnt_d_q || !we_q;
  assign unaligned = gnt_d_q && !wb_q && addr_q[0];

  assign if_rdata = if_rdata_q;
  assign d_rdata  = d_rdata_q;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q    <= IDLE;
      last_d_q   <= 1'b0;
      gnt_d_q    <= 1'b0;
      we_q       <= 1'b0;
      wb_q       <= 1'b0;
      addr_q     <= 16'h0000;
      wdata_q    <= 16'h0000;
      if_rdata_q <= 16'h0000;
      d_rdata_q  <= 16'h0000;
    end else begin
      state_q    <= state_d;
      last_d_q   <= last_d_d;
      gnt_d_q    <= gnt_d_d;
      we_q       <= we_d;
      wb_q       <= wb_d;
      addr_q     <= addr_d;
      wdata_q    <= wdata_d;
      if_rdata_q <= if_rdata_d;
      d_rdata_q  <= d_rdata_d;
    end
  end

  always_comb begin
    state_d    = state_q;
    last_d_d   = last_d_q;
    gnt_d_d    = gnt_d_q;
    we_d       = we_q;
    wb_d       = wb_q;
    addr_d     = addr_q;
    wdata_d    = wdata_q;
    if_rdata_d = if_rdata_q;
    d_rdata_d  = d_rdata_q;
    if_ack     = 1'b0;
    d_ack      = 1'b0;
    m_en       = 1'b0;
    m_we       = 2'b00;
    m_addr     = 15'h0000;
    m_wdata    = 16'h0000;

    case (state_q)
      IDLE: begin
        if (if_req || d_req) begin
          gnt_d_d  = pick_d;
          last_d_d = pick_d;
          if (pick_d) begin
            we_d    = d_we;
            wb_d    = d_wb;
            addr_d  = d_addr;
            wdata_d = d_wdata;
          end else begin
            we_d    = 1'b0;
            wb_d    = 1'b0;
            addr_d  = if_addr & 16'hFFFE;
            wdata_d = 16'h0000;
          end
          state_d = CMD1;
        end
      end

      CMD1: begin
        m_en   = 1'b1;
        m_addr = addr_q[15:1];
        if (!is_read) begin
          if (unaligned) begin
            // High data byte goes to the odd byte of the first word.
            m_we    = 2'b01;
            m_wdata = {wdata_q[15:8], wdata_q[15:8]};
          end else if (wb_q) begin
            m_we    = addr_q[0] ? 2'b01 : 2'b10;
            m_wdata = {wdata_q[7:0], wdata_q[7:0]};
          end else begin
            m_we    = 2'b11;
            m_wdata = wdata_q;
          end
        end
        if (unaligned)
          state_d = CMD2;
        else if (is_read)
          state_d = RWAIT;
        else
          state_d = ACK;
      end

      CMD2: begin
        // Only reached with addr_q[0]=1, so (A+1)>>1 is A[15:1]+1; the 15-bit
        // add wraps 0x7FFF to 0x0000 exactly as A=0xFFFF wraps to 0x0000.
        m_en   = 1'b1;
        m_addr = addr_q[15:1] + 15'd1;
        if (!is_read) begin
          m_we    = 2'b10;
          m_wdata = {wdata_q[7:0], wdata_q[7:0]};
          state_d = ACK;
        end else begin
          // Data of the CMD1 strobe: odd byte of first word is the high byte.
          d_rdata_d = {m_rdata[7:0], d_rdata_q[7:0]};
          state_d   = RWAIT;
        end
      end

      RWAIT: begin
        if (!gnt_d_q)
          if_rdata_d = m_rdata;
        else if (wb_q)
          d_rdata_d = {8'h00, (addr_q[0] ? m_rdata[7:0] : m_rdata[15:8])};
        else if (unaligned)
          d_rdata_d = {d_rdata_q[15:8], m_rdata[15:8]};
        else
          d_rdata_d = m_rdata;
        state_d = ACK;
      end

      ACK: begin
        if_ack  = !gnt_d_q;
        d_ack   = gnt_d_q;
        state_d = IDLE;
      end

      default: state_d = IDLE;
    endcase
  end

endmodule

// File: tb/tb_mem_seq.sv
// -----------------------------------------------------------------------------
// tb_mem_seq : directed testbench for mem_seq with a behavioural memory model.
// -----------------------------------------------------------------------------
module tb_mem_seq;

  logic        clk = 1'b0;
  logic        rst;
  logic        if_req;
  logic [15:0] if_addr;
  logic        if_ack;
  logic [15:0] if_rdata;
  logic        d_req;
  logic        d_we;
  logic        d_wb;
  logic [15:0] d_addr;
  logic [15:0] d_wdata;
  logic        d_ack;
  logic [15:0] d_rdata;
  logic        m_en;
  logic [1:0]  m_we;
  logic [14:0] m_addr;
  logic [15:0] m_wdata;
  logic [15:0] m_rdata;

  always #5 clk = ~clk;

  mem_seq dut (
    .clk     (clk),
    .rst     (rst),
    .if_req  (if_req),
    .if_addr (if_addr),
    .if_ack  (if_ack),
    .if_rdata(if_rdata),
    .d_req   (d_req),
    .d_we    (d_we),
    .d_wb    (d_wb),
    .d_addr  (d_addr),
    .d_wdata (d_wdata),
    .d_ack   (d_ack),
    .d_rdata (d_rdata),
    .m_en    (m_en),
    .m_we    (m_we),
    .m_addr  (m_addr),
    .m_wdata (m_wdata),
    .m_rdata (m_rdata)
  );

  // Memory model: registered read, lane-enabled write, plus a bench poke port.
  logic [15:0] mem [0:32767];
  logic        pl_we = 1'b0;
  logic [14:0] pl_addr;
  logic [15:0] pl_data;

  always @(posedge clk) begin
    if (pl_we) begin
      mem[pl_addr] <= pl_data;
    end else if (m_en) begin
      if (m_we == 2'b00) m_rdata <= mem[m_addr];
      if (m_we[1]) mem[m_addr][15:8] <= m_wdata[15:8];
      if (m_we[0]) mem[m_addr][7:0]  <= m_wdata[7:0];
    end
  end

  int n_vec = 0;
  int n_err = 0;

  task automatic check(input string tag, input logic [31:0] act, input logic [31:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %h expected %h", tag, act, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic poke(input logic [14:0] a, input logic [15:0] v);
    pl_addr = a;
    pl_data = v;
    pl_we   = 1'b1;
    tick();
    pl_we   = 1'b0;
  endtask

  task automatic check_quiet(input string tag);
    check({tag, "_if_ack"},   {31'd0, if_ack}, 0);
    check({tag, "_d_ack"},    {31'd0, d_ack},  0);
    check({tag, "_m_en"},     {31'd0, m_en},   0);
    check({tag, "_m_we"},     {30'd0, m_we},   0);
    check({tag, "_m_addr"},   {17'd0, m_addr}, 0);
    check({tag, "_m_wdata"},  {16'd0, m_wdata}, 0);
    check({tag, "_if_rdata"}, {16'd0, if_rdata}, 0);
    check({tag, "_d_rdata"},  {16'd0, d_rdata}, 0);
  endtask

  // Per-cycle trace of the memory interface; index = cycle number (C1 = 1).
  logic        tr_en   [0:15];
  logic [1:0]  tr_we   [0:15];
  logic [14:0] tr_addr [0:15];
  logic [15:0] tr_wd   [0:15];

  task automatic dacc(input logic we, input logic wb, input logic [15:0] a,
                      input logic [15:0] wd, output int lat, output int nstb);
    d_we = we; d_wb = wb; d_addr = a; d_wdata = wd; d_req = 1'b1;
    lat = 0; nstb = 0;
    for (int c = 1; c <= 12; c++) begin
      tick();
      tr_en[c] = m_en; tr_we[c] = m_we; tr_addr[c] = m_addr; tr_wd[c] = m_wdata;
      if (m_en) nstb++;
      if (d_ack) begin
        lat = c;
        break;
      end
    end
    d_req = 1'b0;
    if (lat == 0) check("d_ack_timeout", 0, 1);
    $display("txn D we=%0b wb=%0b addr=%h wdata=%h lat=%0d strobes=%0d rdata=%h",
             we, wb, a, wd, lat, nstb, d_rdata);
  endtask

  task automatic ifetch(input logic [15:0] a, output int lat);
    if_addr = a; if_req = 1'b1; lat = 0;
    for (int c = 1; c <= 12; c++) begin
      tick();
      tr_addr[c] = m_addr;
      if (if_ack) begin
        lat = c;
        break;
      end
    end
    if_req = 1'b0;
    if (lat == 0) check("if_ack_timeout", 0, 1);
    $display("txn I addr=%h lat=%0d rdata=%h", a, lat, if_rdata);
  endtask

  int lat, ns, ng;
  logic g [0:7];

  initial begin
    rst = 1'b1; if_req = 1'b0; if_addr = 16'h0; d_req = 1'b0;
    d_we = 1'b0; d_wb = 1'b0; d_addr = 16'h0; d_wdata = 16'h0;
    tick();
    poke(15'h0008, 16'hABCD);
    poke(15'h7FFF, 16'h0000);
    poke(15'h0000, 16'h0000);
    poke(15'h0002, 16'h7700);
    poke(15'h0018, 16'hCAFE);
    check_quiet("reset");
    rst = 1'b0;
    tick();

    // Aligned read
    dacc(1'b0, 1'b0, 16'h0010, 16'h0, lat, ns);
    check("ar_lat", lat, 3);
    check("ar_strobes", ns, 1);
    check("ar_addr", {17'd0, tr_addr[1]}, 32'h0008);
    check("ar_rdata", {16'd0, d_rdata}, 32'hABCD);
    tick();

    // Unaligned read
    poke(15'h0008, 16'h1122);
    poke(15'h0009, 16'h3344);
    dacc(1'b0, 1'b0, 16'h0011, 16'h0, lat, ns);
    check("ur_lat", lat, 4);
    check("ur_strobes", ns, 2);
    check("ur_addr1", {17'd0, tr_addr[1]}, 32'h0008);
    check("ur_addr2", {17'd0, tr_addr[2]}, 32'h0009);
    check("ur_rdata", {16'd0, d_rdata}, 32'h2233);
    tick();

    // Unaligned write across the top of memory
    dacc(1'b1, 1'b0, 16'hFFFF, 16'hBEEF, lat, ns);
    check("uw_lat", lat, 3);
    check("uw_addr1", {17'd0, tr_addr[1]}, 32'h7FFF);
    check("uw_we1", {30'd0, tr_we[1]}, 32'h1);
    check("uw_lane1", {24'd0, tr_wd[1][7:0]}, 32'hBE);
    check("uw_addr2", {17'd0, tr_addr[2]}, 32'h0000);
    check("uw_we2", {30'd0, tr_we[2]}, 32'h2);
    check("uw_lane2", {24'd0, tr_wd[2][15:8]}, 32'hEF);
    tick();
    dacc(1'b0, 1'b0, 16'hFFFF, 16'h0, lat, ns);
    check("uw_readback", {16'd0, d_rdata}, 32'hBEEF);
    check("uw_rb_lat", lat, 4);
    tick();

    // Byte write then byte reads of both halves
    dacc(1'b1, 1'b1, 16'h0005, 16'h005A, lat, ns);
    check("bw_lat", lat, 2);
    check("bw_we", {30'd0, tr_we[1]}, 32'h1);
    tick();
    dacc(1'b0, 1'b1, 16'h0005, 16'h0, lat, ns);
    check("br_odd", {16'd0, d_rdata}, 32'h005A);
    check("br_lat", lat, 3);
    tick();
    dacc(1'b0, 1'b1, 16'h0004, 16'h0, lat, ns);
    check("br_even", {16'd0, d_rdata}, 32'h0077);
    tick();

    // Aligned word write and read back
    dacc(1'b1, 1'b0, 16'h0020, 16'h1234, lat, ns);
    check("aw_lat", lat, 2);
    check("aw_we", {30'd0, tr_we[1]}, 32'h3);
    check("aw_wdata", {16'd0, tr_wd[1]}, 32'h1234);
    tick();
    dacc(1'b0, 1'b0, 16'h0020, 16'h0, lat, ns);
    check("aw_readback", {16'd0, d_rdata}, 32'h1234);
    tick();

    // Fetch with odd address: bit 0 ignored, d_rdata untouched
    ifetch(16'h0031, lat);
    check("if_lat", lat, 3);
    check("if_addr", {17'd0, tr_addr[1]}, 32'h0018);
    check("if_rdata", {16'd0, if_rdata}, 32'hCAFE);
    check("if_d_hold", {16'd0, d_rdata}, 32'h1234);
    tick();

    // Reset during CMD2 of an unaligned read
    d_we = 1'b0; d_wb = 1'b0; d_addr = 16'h0011; d_req = 1'b1;
    tick();
    tick();
    check("rst_in_cmd2", {17'd0, m_addr}, 32'h0009);
    #2 rst = 1'b1;
    #1;
    check_quiet("midrst");
    d_req = 1'b0;
    for (int c = 0; c < 3; c++) begin
      tick();
      check("midrst_no_ack", {31'd0, d_ack}, 0);
      check("midrst_no_en", {31'd0, m_en}, 0);
    end
    rst = 1'b0;
    tick();
    dacc(1'b0, 1'b0, 16'h0011, 16'h0, lat, ns);
    check("post_rst_lat", lat, 4);
    check("post_rst_rdata", {16'd0, d_rdata}, 32'h2233);
    tick();

    // Both requests held from reset: grants alternate D, I, D, I ...
    rst = 1'b1;
    tick();
    d_we = 1'b0; d_wb = 1'b0; d_addr = 16'h0010; d_req = 1'b1;
    if_addr = 16'h0030; if_req = 1'b1;
    tick();
    rst = 1'b0;
    ng = 0;
    for (int c = 0; c < 80 && ng < 6; c++) begin
      tick();
      check("ack_overlap", {31'd0, if_ack & d_ack}, 0);
      if (d_ack) begin g[ng] = 1'b1; ng++; end
      else if (if_ack) begin g[ng] = 1'b0; ng++; end
    end
    if_req = 1'b0; d_req = 1'b0;
    check("rr_count", ng, 6);
    for (int k = 0; k < 6; k++) begin
      $display("txn RR grant %0d = %s", k, g[k] ? "D" : "I");
      check($sformatf("rr_grant%0d", k), {31'd0, g[k]}, {31'd0, ~k[0]});
    end
    tick();
    tick();

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
